// File: rtl/cic5_frame_ctrl.sv
// Sequencer for a cic5 decimator: gates the filter, discards the settling outputs and
// packs decimated samples into FRAME_LEN frames through a small registered FIFO.
module cic5_frame_ctrl #(
  parameter int IN_W       = 16,
  parameter int OUT_W      = 28,
  parameter int SETTLE     = 5,
  parameter int FRAME_LEN  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             src_valid,
  input  logic [IN_W-1:0]  src_data,
  output logic             cic_rst_n,
  output logic [IN_W-1:0]  cic_din,
  input  logic [OUT_W-1:0] cic_dout,
  input  logic             cic_dout_valid,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             m_last,
  output logic             busy,
  output logic             overflow,
  output logic             underrun,
  output logic [1:0]       state
);

  localparam int SW          = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int FW          = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int AW          = $clog2(FIFO_DEPTH);
  localparam int CW          = AW + 1;
  localparam int SETTLE_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RUN    = 2'd2,
    S_DRAIN  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic            cic_rst_n_q;
  logic            overflow_q, underrun_q;
  logic [OUT_W:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic pop, full, capture, push, drop, frame_end;

  assign pop       = m_valid & m_ready;
  assign full      = (cnt_q == CW'(FIFO_DEPTH));
  assign capture   = cic_dout_valid & ((state_q == S_RUN) | (state_q == S_DRAIN));
  // A full FIFO still accepts when its head leaves in the same cycle.
  assign push      = capture & (~full | pop);
  assign drop      = capture & full & ~pop;
  assign frame_end = (frame_q == FW'(FRAME_LEN - 1));
  assign cnt_d     = cnt_q + CW'(push) - CW'(pop);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    frame_d  = frame_q;
    if (push) frame_d = frame_end ? '0 : frame_q + FW'(1);
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          settle_d = '0;
          frame_d  = '0;
          state_d  = (SETTLE > 0) ? S_SETTLE : S_RUN;
        end
      end
      S_SETTLE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (cic_dout_valid) begin
          settle_d = settle_q + SW'(1);
          if (settle_q == SW'(SETTLE_LAST)) state_d = S_RUN;
        end
      end
      // Stopping mid-frame finishes the frame so the consumer never sees a partial one.
      S_RUN: begin
        if (stop) state_d = (frame_d == '0) ? S_IDLE : S_DRAIN;
      end
      S_DRAIN: begin
        if (push && frame_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      settle_q    <= '0;
      frame_q     <= '0;
      cic_rst_n_q <= 1'b0;
      overflow_q  <= 1'b0;
      underrun_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      frame_q     <= frame_d;
      cic_rst_n_q <= (state_d != S_IDLE);
      if (drop) overflow_q <= 1'b1;
      if ((state_q != S_IDLE) && !src_valid) underrun_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {frame_end, cic_dout};
  end

  assign cic_din   = ((state_q != S_IDLE) && src_valid) ? src_data : '0;
  assign cic_rst_n = cic_rst_n_q;
  assign m_valid   = (cnt_q != '0);
  assign m_data    = mem_q[rd_ptr_q][OUT_W-1:0];
  assign m_last    = mem_q[rd_ptr_q][OUT_W];
  assign busy      = (state_q != S_IDLE) || (cnt_q != '0);
  assign overflow  = overflow_q;
  assign underrun  = underrun_q;
  assign state     = state_q;

endmodule

// File: tb/tb_cic5_frame_ctrl.sv
// Bench for cic5_frame_ctrl with a behavioural cic5 stand-in (DC gain 5^5, one output per 5 clocks).
module tb_cic5_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, stop, src_valid, m_ready;
  logic [15:0] src_data;
  logic        cic_rst_n;
  logic [15:0] cic_din;
  logic [27:0] cic_dout;
  logic        cic_dout_valid;
  logic        m_valid, m_last, busy, overflow, underrun;
  logic [27:0] m_data;
  logic [1:0]  state;

  int total = 0;
  int bad   = 0;
  int beat_cnt = 0;
  logic chk_data = 1'b0;

  always #5 clk = ~clk;

  cic5_frame_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .src_valid(src_valid), .src_data(src_data),
    .cic_rst_n(cic_rst_n), .cic_din(cic_din),
    .cic_dout(cic_dout), .cic_dout_valid(cic_dout_valid),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .overflow(overflow), .underrun(underrun), .state(state)
  );

  // Filter stand-in: the first 5 outputs after release are small transient markers 0..4.
  int ph, nout;
  logic signed [27:0] din_ext;
  assign din_ext = {{12{cic_din[15]}}, cic_din};
  always @(posedge clk) begin
    if (!cic_rst_n) begin
      ph <= 0; nout <= 0; cic_dout_valid <= 1'b0; cic_dout <= '0;
    end else begin
      cic_dout_valid <= (ph == 4);
      ph <= (ph == 4) ? 0 : ph + 1;
      if (ph == 4) begin
        cic_dout <= (nout < 5) ? 28'(nout) : din_ext * 28'sd3125;
        nout <= nout + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Account for the beat (if any) that pops at the coming edge, then step one clock.
  task automatic cyc(output logic b, output logic l);
    b = m_valid && m_ready;
    l = m_last;
    if (b) begin
      chk("m_last_pos", {31'd0, m_last}, {31'd0, (beat_cnt % 8) == 7});
      if (chk_data) chk("m_data", {4'd0, m_data}, 32'd102396875);
      beat_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; src_valid = 1'b0; src_data = '0; m_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    beat_cnt = 0;
  endtask

  typedef struct {
    logic        start;
    logic        stop;
    logic        vld;
    logic [15:0] dat;
    logic [15:0] exp_din;
    logic [1:0]  exp_state;
    logic        exp_rst_n;
  } vec_t;

  vec_t vt[8];
  logic b, l, st_ok, have, hl, found;
  logic [1:0]  st;
  logic [27:0] hd;
  int n;

  initial begin
    vt[0] = '{1'b1, 1'b1, 1'b1, 16'h1234, 16'h0000, 2'd0, 1'b0};
    vt[1] = '{1'b0, 1'b0, 1'b1, 16'h0005, 16'h0000, 2'd0, 1'b0};
    vt[2] = '{1'b1, 1'b0, 1'b1, 16'h7fff, 16'h0000, 2'd1, 1'b1};
    vt[3] = '{1'b0, 1'b0, 1'b1, 16'h8000, 16'h8000, 2'd1, 1'b1};
    vt[4] = '{1'b0, 1'b0, 1'b0, 16'h1111, 16'h0000, 2'd1, 1'b1};
    vt[5] = '{1'b1, 1'b0, 1'b1, 16'h0042, 16'h0042, 2'd1, 1'b1};
    vt[6] = '{1'b0, 1'b1, 1'b1, 16'h0007, 16'h0007, 2'd0, 1'b0};
    vt[7] = '{1'b0, 1'b0, 1'b1, 16'h0009, 16'h0000, 2'd0, 1'b0};

    // 1: idle after reset
    do_reset();
    for (int i = 0; i < 20; i++) begin
      chk("t1_cic_rst_n", {31'd0, cic_rst_n}, 32'd0);
      chk("t1_m_valid",   {31'd0, m_valid},   32'd0);
      chk("t1_busy",      {31'd0, busy},      32'd0);
      chk("t1_state",     {30'd0, state},     32'd0);
      cyc(b, l);
    end

    // 2: full-scale DC input, transient discarded, framing every 8 beats
    src_valid = 1'b1; src_data = 16'h7fff; m_ready = 1'b1; chk_data = 1'b1;
    start = 1'b1; cyc(b, l); start = 1'b0;
    for (int i = 0; i < 400 && beat_cnt < 16; i++) cyc(b, l);
    chk("t2_beats", beat_cnt, 32'd16);
    chk("t2_overflow", {31'd0, overflow}, 32'd0);
    chk("t2_underrun", {31'd0, underrun}, 32'd0);

    // 3: consumer stalls 40 cycles; head held, drops flagged, framing continues
    chk_data = 1'b0; have = 1'b0; hd = '0; hl = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      src_data = 16'($urandom);
      cyc(b, l);
      if (have) begin
        st_ok = m_valid && (m_last == hl) && (m_data == hd);
        chk("t3_hold", {31'd0, st_ok}, 32'd1);
      end else if (m_valid) begin
        have = 1'b1; hd = m_data; hl = m_last;
      end
    end
    chk("t3_valid_seen", {31'd0, have}, 32'd1);
    chk("t3_overflow", {31'd0, overflow}, 32'd1);
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      src_data = 16'($urandom);
      cyc(b, l);
      chk("t3_burst", {31'd0, b}, 32'd1);
    end
    n = beat_cnt + 12;
    for (int i = 0; i < 300 && beat_cnt < n; i++) begin
      src_data = 16'($urandom);
      cyc(b, l);
    end
    chk("t3_resume", beat_cnt, n);

    // 4: stop after the 3rd sample of a frame -> DRAIN completes the frame
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cyc(b, l);
      if (b && (beat_cnt % 8) == 3) begin found = 1'b1; break; end
    end
    chk("t4_align", {31'd0, found}, 32'd1);
    n = 0;
    stop = 1'b1; cyc(b, l); stop = 1'b0;
    if (b) n++;
    chk("t4_drain", {30'd0, state}, 32'd3);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      st = state;
      cyc(b, l);
      if (b) begin
        n++;
        if (l) begin
          chk("t4_idle_at_last", {30'd0, st}, 32'd0);
          found = 1'b1;
          break;
        end else begin
          chk("t4_drain_hold", {30'd0, st}, 32'd3);
        end
      end
    end
    chk("t4_last_seen", {31'd0, found}, 32'd1);
    chk("t4_beats", n, 32'd5);
    for (int i = 0; i < 10; i++) cyc(b, l);
    chk("t4_m_valid", {31'd0, m_valid}, 32'd0);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_state", {30'd0, state}, 32'd0);
    chk("t4_cic_rst_n", {31'd0, cic_rst_n}, 32'd0);

    // 5: start+stop together, cic_din gating, stop during SETTLE
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      start = vt[i].start; stop = vt[i].stop; src_valid = vt[i].vld; src_data = vt[i].dat;
      #3;
      chk("t5_cic_din", {16'd0, cic_din}, {16'd0, vt[i].exp_din});
      chk("t5_m_valid", {31'd0, m_valid}, 32'd0);
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0;
      chk("t5_state", {30'd0, state}, {30'd0, vt[i].exp_state});
      chk("t5_cic_rst_n", {31'd0, cic_rst_n}, {31'd0, vt[i].exp_rst_n});
    end
    chk("t5_underrun", {31'd0, underrun}, 32'd1);

    // 6: underrun is sticky; reset mid-run clears everything next cycle
    do_reset();
    src_valid = 1'b1; src_data = 16'h0100; m_ready = 1'b1;
    start = 1'b1; cyc(b, l); start = 1'b0;
    for (int i = 0; i < 100 && state != 2'd2; i++) cyc(b, l);
    chk("t6_run", {30'd0, state}, 32'd2);
    for (int i = 0; i < 20; i++) cyc(b, l);
    chk("t6_no_underrun", {31'd0, underrun}, 32'd0);
    src_valid = 1'b0; cyc(b, l); src_valid = 1'b1;
    chk("t6_underrun", {31'd0, underrun}, 32'd1);
    for (int i = 0; i < 3; i++) cyc(b, l);
    chk("t6_underrun_sticky", {31'd0, underrun}, 32'd1);
    m_ready = 1'b0;
    for (int i = 0; i < 15; i++) cyc(b, l);
    chk("t6_pre_valid", {31'd0, m_valid}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_state", {30'd0, state}, 32'd0);
    chk("t6_cic_rst_n", {31'd0, cic_rst_n}, 32'd0);
    chk("t6_m_valid", {31'd0, m_valid}, 32'd0);
    chk("t6_m_last", {31'd0, m_last}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_overflow", {31'd0, overflow}, 32'd0);
    chk("t6_underrun_clr", {31'd0, underrun}, 32'd0);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
